// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// counter sizing helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit slice adder; also reports the carry into the slice MSB
// so the top can derive signed overflow from the final slice.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  assign s    = full[DIGIT-1:0];
  assign co   = full[DIGIT];
  // The MSB sum bit is x^y^carry_in, so the carry in falls out by XORing back.
  assign c_msb_in = x[DIGIT-1] ^ y[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/seq_digit_adder.sv
// Digit-serial adder/subtractor: accepts an operand pair, adds one DIGIT-bit slice
// per cycle LSB first, then holds the result until the consumer takes it.
module seq_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_e           state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and each side holds until the transfer.

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             cout_r, ovf_r;
  logic [DIGIT-1:0] sl_s;
  logic             sl_co, sl_cmsb;
  logic             last;
  logic [WIDTH-1:0] sum_shifted;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x        (a_sh[DIGIT-1:0]),
    .y        (b_sh[DIGIT-1:0]),
    .ci       (carry),
    .s        (sl_s),
    .co       (sl_co),
    .c_msb_in (sl_cmsb)
  );

  assign last        = (cnt == CW'(N - 1));
  assign sum_shifted = (sum_r >> DIGIT) | (WIDTH'(sl_s) << (WIDTH - DIGIT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b up front and seed the carry.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            sum_r <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          sum_r <= sum_shifted;
          carry <= sl_co;
          if (last) begin
            cout_r <= sl_co;
            ovf_r  <= sl_co ^ sl_cmsb;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_digit_adder.sv
// Directed bench for seq_digit_adder (8/2 instance) plus exhaustive 4-bit sweeps
// of the single-slice and bit-serial configurations.
module tb_seq_digit_adder;
  import adder_pkg::*;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (WIDTH=8, DIGIT=2) ----------------
  logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, cout, ovf;
  logic [7:0] sum;
  state_e     state_dbg;

  seq_digit_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  // ---------------- 4-bit DUTs for the sweep ----------------
  logic       e_in_valid = 1'b0, e_out_ready = 1'b0, e_cin = 1'b0, e_sub = 1'b0;
  logic [3:0] e_a = '0, e_b = '0;
  logic       w4_in_ready, w4_out_valid, w4_cout, w4_ovf;
  logic [3:0] w4_sum;
  state_e     w4_state;
  logic       w1_in_ready, w1_out_valid, w1_cout, w1_ovf;
  logic [3:0] w1_sum;
  state_e     w1_state;

  seq_digit_adder #(.WIDTH(4), .DIGIT(4)) dut_w4d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(w4_in_ready),
    .a(e_a), .b(e_b), .cin(e_cin), .sub(e_sub), .out_valid(w4_out_valid),
    .out_ready(e_out_ready), .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf),
    .state_dbg(w4_state)
  );

  seq_digit_adder #(.WIDTH(4), .DIGIT(1)) dut_w4d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(w1_in_ready),
    .a(e_a), .b(e_b), .cin(e_cin), .sub(e_sub), .out_valid(w1_out_valid),
    .out_ready(e_out_ready), .sum(w1_sum), .cout(w1_cout), .ovf(w1_ovf),
    .state_dbg(w1_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns edges from accept to out_valid.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is, output int lat);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'd0 || cout !== 1'b0 ||
        ovf !== 1'b0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%0d cout=%b ovf=%b state=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf, state_dbg);
    end
  endtask

  task automatic test_add();
    int lat;
    do_op(8'd200, 8'd100, 1'b1, 1'b0, lat);
    n_vec++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL add_latency: got %0d want 4", lat);
    end
    n_vec++;
    if (sum !== 8'd45 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL add_result: sum=%0d cout=%b ovf=%b want 45 1 0", sum, cout, ovf);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int lat;
    logic [7:0] va [3]  = '{8'd127, 8'd128, 8'd5};
    logic [7:0] vb [3]  = '{8'd1,   8'd1,   8'd7};
    logic       vs [3]  = '{1'b0,   1'b1,   1'b1};
    logic [7:0] es [3]  = '{8'd128, 8'd127, 8'd254};
    logic       ec [3]  = '{1'b0,   1'b1,   1'b0};
    logic       eo [3]  = '{1'b1,   1'b1,   1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, vs[i], lat);
      n_vec++;
      if (lat !== 4 || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        n_bad++;
        $display("FAIL overflow_%0d: lat=%0d sum=%0d cout=%b ovf=%b want 4 %0d %b %b",
                 i, lat, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 8'd10; b = 8'd20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    // Scramble every operand input while the operation is in flight.
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_run_ready: in_ready=%b want 0", in_ready);
      end
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'd30 ||
          cout !== 1'b0 || ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%0d cout=%b ovf=%b want 1 0 30 0 0",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    a = 8'd50; b = 8'd60; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'd0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL rst_async: out_valid=%b in_ready=%b sum=%0d state=%0d want 0 1 0 0",
               out_valid, in_ready, sum, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL rst_discard: bad idle cycles=%0d want 0", seen);
    end
    do_op(8'd3, 8'd4, 1'b0, 1'b0, lat);
    n_vec++;
    if (lat !== 4 || sum !== 8'd7 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_next_op: lat=%0d sum=%0d cout=%b ovf=%b want 4 7 0 0", lat, sum, cout, ovf);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    do_op(8'd1, 8'd2, 1'b0, 1'b0, lat);
    n_vec++;
    if (lat !== 4 || sum !== 8'd3 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first: lat=%0d sum=%0d in_ready=%b want 4 3 0", lat, sum, in_ready);
    end
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_handoff: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    do_op(8'd255, 8'd255, 1'b1, 1'b0, lat);
    n_vec++;
    if (lat !== 4 || sum !== 8'd255 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: lat=%0d sum=%0d cout=%b ovf=%b want 4 255 1 0", lat, sum, cout, ovf);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [4:0] exp_full;
    logic [3:0] bb;
    logic       exp_ovf;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            e_a = 4'(ia); e_b = 4'(ib); e_cin = ic[0]; e_sub = is[0];
            bb = e_sub ? ~e_b : e_b;
            exp_full = e_sub ? ({1'b0, e_a} + {1'b0, ~e_b} + 5'd1)
                             : ({1'b0, e_a} + {1'b0, e_b} + {4'd0, e_cin});
            exp_ovf = (e_a[3] == bb[3]) && (exp_full[3] != e_a[3]);
            n_vec++;
            if (w4_in_ready !== 1'b1 || w1_in_ready !== 1'b1) begin
              n_bad++; $display("FAIL ex_ready a=%0d b=%0d: %b %b want 1 1", ia, ib, w4_in_ready, w1_in_ready);
            end
            e_in_valid = 1'b1;
            tick();
            e_in_valid = 1'b0;
            e_a = ~e_a; e_b = ~e_b;
            tick();
            n_vec++;
            if (w4_out_valid !== 1'b1 || w1_out_valid !== 1'b0) begin
              n_bad++;
              $display("FAIL ex_lat1 a=%0d b=%0d c=%0d s=%0d: d4=%b d1=%b want 1 0",
                       ia, ib, ic, is, w4_out_valid, w1_out_valid);
            end
            tick();
            tick();
            n_vec++;
            if (w1_out_valid !== 1'b0) begin
              n_bad++; $display("FAIL ex_early a=%0d b=%0d: d1 out_valid=%b want 0", ia, ib, w1_out_valid);
            end
            tick();
            n_vec++;
            if (w1_out_valid !== 1'b1 || {w4_cout, w4_sum} !== exp_full || w4_ovf !== exp_ovf ||
                {w1_cout, w1_sum} !== exp_full || w1_ovf !== exp_ovf) begin
              n_bad++;
              $display("FAIL ex_res a=%0d b=%0d c=%0d s=%0d: d4=%0d/%b d1=%0d/%b v=%b want %0d/%b",
                       ia, ib, ic, is, {w4_cout, w4_sum}, w4_ovf, {w1_cout, w1_sum}, w1_ovf,
                       w1_out_valid, exp_full, exp_ovf);
            end
            e_out_ready = 1'b1;
            tick();
            e_out_ready = 1'b0;
          end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_add();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
